// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer driving the PC counter's en/load/sel/offset/base controls.
// Optional fetch timeout is enabled by defining FETCH_TIMEOUT_EN (sticky fetch_err, then HALT).
module pc_fetch_ctrl #(
    parameter int PC_W    = 16,
    parameter int OFF_W   = 8,
    parameter int TMO_CYC = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run,
    input  logic [PC_W-1:0]  pc_q,
    input  logic             zflag,
    input  logic [PC_W-1:0]  jr_base,
    output logic             mem_req,
    output logic [PC_W-1:0]  mem_addr,
    input  logic             mem_ready,
    input  logic [PC_W-1:0]  mem_rdata,
    output logic [PC_W-1:0]  ir,
    output logic             ir_valid,
    output logic             pc_en,
    output logic             pc_load,
    output logic             pc_sel,
    output logic [OFF_W-1:0] pc_offset,
    output logic [PC_W-1:0]  pc_base,
    output logic             halted,
    output logic             fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_UPDATE,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_BR   = 4'h8;
    localparam logic [3:0] OP_BZ   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JR   = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t state;

    logic [3:0]       opcode;
    logic             dec_load;
    logic             dec_sel;
    logic [OFF_W-1:0] dec_off;
    logic [PC_W-1:0]  dec_base;
    logic             accept;

    assign opcode = ir[PC_W-1 -: 4];
    assign accept = mem_req & mem_ready;

    // pc_q only moves on the UPDATE edge, so while mem_req is up it equals the PC seen on FETCH entry.
    assign mem_addr = mem_req ? pc_q : '0;

    always_comb begin
        dec_load = 1'b0;
        dec_sel  = 1'b0;
        dec_off  = '0;
        dec_base = '0;
        unique case (opcode)
            OP_BR: begin
                dec_load = 1'b1;
                dec_sel  = 1'b1;
                dec_off  = ir[OFF_W-1:0];
            end
            OP_BZ: begin
                if (zflag) begin
                    dec_load = 1'b1;
                    dec_sel  = 1'b1;
                    dec_off  = ir[OFF_W-1:0];
                end
            end
            OP_JMP: begin
                dec_load = 1'b1;
                dec_base = {4'h0, ir[PC_W-5:0]};
            end
            OP_JR: begin
                dec_load = 1'b1;
                dec_off  = ir[OFF_W-1:0];
                dec_base = jr_base;
            end
            default: ;
        endcase
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
    logic [TW-1:0] tmo_cnt;
`else
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            ir        <= '0;
            ir_valid  <= 1'b0;
            pc_en     <= 1'b0;
            pc_load   <= 1'b0;
            pc_sel    <= 1'b0;
            pc_offset <= '0;
            pc_base   <= '0;
            halted    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt   <= '0;
            fetch_err <= 1'b0;
`endif
        end else begin
            ir_valid <= 1'b0;
            pc_en    <= 1'b0;
            pc_load  <= 1'b0;
            pc_sel   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state   <= S_FETCH;
                        mem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                S_FETCH: begin
                    if (accept) begin
                        ir       <= mem_rdata;
                        ir_valid <= 1'b1;
                        mem_req  <= 1'b0;
                        state    <= S_DECODE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        fetch_err <= 1'b1;
                        mem_req   <= 1'b0;
                        halted    <= 1'b1;
                        state     <= S_HALT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                S_DECODE: begin
                    if (opcode == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        // Controls are registered here so they are stable for the whole UPDATE cycle.
                        pc_en     <= 1'b1;
                        pc_load   <= dec_load;
                        pc_sel    <= dec_sel;
                        pc_offset <= dec_off;
                        pc_base   <= dec_base;
                        state     <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (run) begin
                        state   <= S_FETCH;
                        mem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: counter and memory models around the DUT, table-driven instruction stream.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rstn;
    logic        run;
    logic [15:0] pc_q;
    logic        zflag;
    logic [15:0] jr_base;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic [15:0] ir;
    logic        ir_valid;
    logic        pc_en;
    logic        pc_load;
    logic        pc_sel;
    logic [7:0]  pc_offset;
    logic [15:0] pc_base;
    logic        halted;
    logic        fetch_err;

    logic        pc_set_req;
    logic [15:0] pc_set_val;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] instr;
        logic        z;
        logic [15:0] jrb;
        int          dly;
        logic [15:0] addr;
        logic        load;
        logic        sel;
        logic [7:0]  off;
        logic [15:0] base;
        logic        chk_ob;
        logic        halt;
    } vec_t;

    typedef struct packed {
        logic        load;
        logic        sel;
        logic [7:0]  off;
        logic [15:0] base;
        logic        chk_ob;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];

    pc_fetch_ctrl #(.PC_W(16), .OFF_W(8), .TMO_CYC(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .run       (run),
        .pc_q      (pc_q),
        .zflag     (zflag),
        .jr_base   (jr_base),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .pc_en     (pc_en),
        .pc_load   (pc_load),
        .pc_sel    (pc_sel),
        .pc_offset (pc_offset),
        .pc_base   (pc_base),
        .halted    (halted),
        .fetch_err (fetch_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference PC counter: inc, BASE+sext(OFF), or Q+BASE+sext(OFF), wrapping at 16 bits.
    always @(posedge clk) begin
        if (pc_set_req)
            pc_q <= pc_set_val;
        else if (pc_en) begin
            if (pc_load)
                pc_q <= (pc_sel ? pc_q : 16'h0000) + pc_base + {{8{pc_offset[7]}}, pc_offset};
            else
                pc_q <= pc_q + 16'h0001;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_instr(input vec_t v, input bit drop_run);
        int   n;
        exp_t e;
        zflag     = v.z;
        jr_base   = v.jrb;
        mem_rdata = v.instr;
        mem_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 20);
        chk("fetch_req", 32'(mem_req), 32'd1);
        chk("fetch_addr", 32'(mem_addr), 32'(v.addr));
        chk("pc_en_width", 32'(pc_en), 32'd0);
        if (drop_run) run = 1'b0;
        n = 0;
        repeat (v.dly - 1) begin
            @(negedge clk);
            if (!mem_req || pc_en) n++;
        end
        chk("req_held", 32'(n), 32'd0);
        mem_ready = 1'b1;
        if (!v.halt) sb.push_back('{v.load, v.sel, v.off, v.base, v.chk_ob});
        @(negedge clk);
        mem_ready = 1'b0;
        chk("ir_valid", 32'(ir_valid), 32'd1);
        chk("ir", 32'(ir), 32'(v.instr));
        chk("req_drop", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("ir_valid_pulse", 32'(ir_valid), 32'd0);
        if (v.halt) begin
            chk("halted", 32'(halted), 32'd1);
            chk("halt_no_pc_en", 32'(pc_en), 32'd0);
        end else begin
            chk("pc_en", 32'(pc_en), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_load", 32'(pc_load), 32'(e.load));
                chk("pc_sel", 32'(pc_sel), 32'(e.sel));
                if (e.chk_ob) begin
                    chk("pc_offset", 32'(pc_offset), 32'(e.off));
                    chk("pc_base", 32'(pc_base), 32'(e.base));
                end
            end
            chk("not_halted", 32'(halted), 32'd0);
        end
    endtask

    initial begin
        int   bad;
        int   n;
        vec_t v;

        //         instr     z     jrb       dly addr      ld    sel   off    base      ob    halt
        vecs[0] = '{16'h1234, 1'b0, 16'h0000, 1, 16'h0010, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{16'h80FE, 1'b0, 16'h0000, 1, 16'h0011, 1'b1, 1'b1, 8'hFE, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h9005, 1'b1, 16'h0000, 1, 16'h000F, 1'b1, 1'b1, 8'h05, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h9005, 1'b0, 16'h0000, 1, 16'h0014, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{16'hA123, 1'b0, 16'h0000, 1, 16'h0015, 1'b1, 1'b0, 8'h00, 16'h0123, 1'b1, 1'b0};
        vecs[5] = '{16'hB0FF, 1'b0, 16'h0200, 2, 16'h0123, 1'b1, 1'b0, 8'hFF, 16'h0200, 1'b1, 1'b0};
        vecs[6] = '{16'hB000, 1'b0, 16'hFFFF, 1, 16'h01FF, 1'b1, 1'b0, 8'h00, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'h8001, 1'b0, 16'h0000, 5, 16'hFFFF, 1'b1, 1'b1, 8'h01, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{16'h7FFF, 1'b0, 16'h0000, 3, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0};
        vecs[9] = '{16'hF000, 1'b0, 16'h0000, 1, 16'h0001, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1};

        rstn       = 1'b0;
        run        = 1'b0;
        zflag      = 1'b0;
        jr_base    = 16'h0000;
        mem_ready  = 1'b0;
        mem_rdata  = 16'h0000;
        pc_set_req = 1'b1;
        pc_set_val = 16'h0010;
        repeat (3) @(negedge clk);
        pc_set_req = 1'b0;

        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_ir", 32'(ir), 32'd0);
        chk("rst_pc_offset", 32'(pc_offset), 32'd0);
        chk("rst_pc_base", 32'(pc_base), 32'd0);
        chk("rst_ctrl", 32'({pc_en, pc_load, pc_sel, ir_valid, halted, fetch_err}), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);

        rstn = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req || pc_en || pc_load || pc_sel || ir_valid || halted || fetch_err ||
                ir != 16'h0 || pc_offset != 8'h0 || pc_base != 16'h0)
                bad++;
        end
        chk("idle_quiet", 32'(bad), 32'd0);

        run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            do_instr(vecs[i], 1'b0);
        end

        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!halted || mem_req || pc_en) bad++;
        end
        chk("halt_sticky", 32'(bad), 32'd0);
        chk("halt_pc", 32'(pc_q), 32'h0001);

        // Reset in the middle of a stalled fetch.
        rstn       = 1'b0;
        run        = 1'b0;
        pc_set_req = 1'b1;
        pc_set_val = 16'h0040;
        @(negedge clk);
        pc_set_req = 1'b0;
        rstn       = 1'b1;
        chk("rst_clears_halt", 32'(halted), 32'd0);
        run       = 1'b1;
        mem_rdata = 16'h8010;
        mem_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 20);
        chk("midrst_addr", 32'(mem_addr), 32'h0040);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_req_drop", 32'(mem_req), 32'd0);
        run = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (pc_en || mem_req || ir_valid) bad++;
        end
        chk("midrst_no_pulse", 32'(bad), 32'd0);
        chk("midrst_pc", 32'(pc_q), 32'h0040);

        // run dropped during FETCH: the instruction completes, then the FSM idles.
        run = 1'b1;
        v = '{16'h2222, 1'b0, 16'h0000, 2, 16'h0040, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0};
        do_instr(v, 1'b1);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_req || pc_en) bad++;
        end
        chk("run_drop_idle", 32'(bad), 32'd0);
        chk("run_drop_pc", 32'(pc_q), 32'h0041);

`ifdef FETCH_TIMEOUT_EN
        run       = 1'b1;
        mem_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 20);
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_cycles", 32'(n), 32'd16);
        chk("tmo_fetch_err", 32'(fetch_err), 32'd1);
        chk("tmo_halted", 32'(halted), 32'd1);
`else
        chk("fetch_err_tied", 32'(fetch_err), 32'd0);
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
